sram_like_resp: RTL and testbench

//  Responder (slave) end of the sram-like req/addr_ok/data_ok bus that the CPU core drives on its

---
 rtl/sram_like_resp.sv | 138 +++++++++++++
 tb/tb_sram_like_resp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// sram_like_resp: responder end of the sram-like req/addr_ok/data_ok bus.
// Word-addressed memory (not reset), writes land at the address handshake,
// and responses for every accepted request return strictly in order after
// LAT cycles through a small outstanding-request queue.
module sram_like_resp #(
    parameter int AW    = 10,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        addr_stall,
    input  logic        data_stall
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT   = CW'(LAT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(DEPTH);

    // Merge write data into an existing word under byte enables.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]      mem_r [0:(1<<AW)-1];
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] is_wr_r;
    logic [31:0]      data_r [0:DEPTH-1];
    logic [CW-1:0]    cnt_r  [0:DEPTH-1];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [PW:0]      count_r;

    logic [AW-1:0]    idx_s;
    logic [31:0]      rd_word_s;
    logic             push_s;
    logic             pop_s;
    logic             unused_s;

    // Size and the byte offset/upper address bits carry no meaning here.
    assign unused_s = ^{size, addr[31:AW+2], addr[1:0]};
    assign idx_s    = addr[AW+1:2];

    // Handshake decode: accept/return conditions and the response word.
    always_comb begin
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = 32'h0000_0000;
        rd_word_s = 32'h0000_0000;
        if (!reset) begin
            addr_ok = ~addr_stall & (count_r < COUNT_FULL);
            data_ok = valid_r[head_r] & (cnt_r[head_r] == '0) & ~data_stall;
        end else begin
            addr_ok = 1'b0;
            data_ok = 1'b0;
        end
        if (data_ok) begin
            rdata = is_wr_r[head_r] ? 32'h0000_0000 : data_r[head_r];
        end else begin
            rdata = 32'h0000_0000;
        end
        if (wr) begin
            rd_word_s = 32'h0000_0000;
        end else begin
            rd_word_s = mem_r[idx_s];
        end
    end

    assign push_s = req & addr_ok;
    assign pop_s  = data_ok;

    // Memory update for accepted writes; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (push_s && wr) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata, wstrb);
        end
    end

    // Outstanding-request queue: latency countdown, push on accept, pop on data_ok.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
            is_wr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= 32'h0000_0000;
                cnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && (cnt_r[i] != '0)) begin
                    cnt_r[i] <= cnt_r[i] - CNT_ONE;
                end
            end
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_ONE;
            end
            if (push_s) begin
                valid_r[tail_r] <= 1'b1;
                is_wr_r[tail_r] <= wr;
                data_r[tail_r]  <= rd_word_s;
                cnt_r[tail_r]   <= CNT_INIT;
                tail_r          <= tail_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Self-checking bench for sram_like_resp: a queue/array model of the bus
// rules checked every cycle, plus literal expectations for the directed cases.
module tb_sram_like_resp;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        addr_stall = 1'b0;
    logic        data_stall = 1'b0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mmem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    sram_like_resp #(.AW(AW), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .addr_stall(addr_stall), .data_stall(data_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Per-cycle model: outstanding responses with due cycles, plus a memory image.
    always @(negedge clk) begin : model
        logic          exp_aok;
        logic          exp_dok;
        logic [AW-1:0] widx;
        resp_t         ent;
        cyc++;
        if (reset) begin
            q.delete();
            chk1("rst_addr_ok", addr_ok, 1'b0);
            chk1("rst_data_ok", data_ok, 1'b0);
            chk("rst_rdata", rdata, 32'h0);
        end else begin
            exp_aok = !addr_stall && (q.size() < DEPTH);
            exp_dok = (q.size() > 0) && !data_stall && (q[0].due <= cyc);
            chk1("m_addr_ok", addr_ok, exp_aok);
            chk1("m_data_ok", data_ok, exp_dok);
            if (exp_dok) begin
                chk("m_rdata", rdata, q[0].val);
                void'(q.pop_front());
            end
            if (req && exp_aok) begin
                widx    = addr[AW+1:2];
                ent.due = cyc + LAT;
                if (wr) begin
                    ent.val = 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) mmem[widx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end else begin
                    ent.val = mmem[widx];
                end
                q.push_back(ent);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bit done;
        done  = 1'b0;
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = d;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (addr_ok) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL accept_timeout: addr %h not accepted within 64 cycles", a);
        end
        sync();
        req = 1'b0;
    endtask

    initial begin : stim
        int stale;
        idle(2);
        reset = 1'b0;

        // 1: write then read same word, back to back
        issue(1'b1, 32'h100, 4'hF, 32'h1234_5678);
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        chk1("t1_wr_data_ok", data_ok, 1'b1);
        chk("t1_wr_rdata", rdata, 32'h0);
        @(negedge clk);
        chk1("t1_rd_data_ok", data_ok, 1'b1);
        chk("t1_rd_rdata", rdata, 32'h1234_5678);
        sync();
        idle(2);

        // 2: byte write into lane 2, then a wstrb=0 write, then read
        issue(1'b1, 32'h100, 4'b0100, 32'h00AB_0000);
        idle(3);
        issue(1'b1, 32'h100, 4'b0000, 32'hFFFF_FFFF);
        @(negedge clk);
        chk1("t2_zw_early", data_ok, 1'b0);
        @(negedge clk);
        chk1("t2_zw_data_ok", data_ok, 1'b1);
        chk("t2_zw_rdata", rdata, 32'h0);
        sync();
        idle(2);
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        chk1("t2_rd_early", data_ok, 1'b0);
        @(negedge clk);
        chk1("t2_rd_data_ok", data_ok, 1'b1);
        chk("t2_rd_rdata", rdata, 32'h12AB_5678);
        sync();
        idle(2);

        // 3: fill the queue under data_stall, then drain
        for (int i = 0; i < 6; i++) issue(1'b1, 32'h200 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i));
        idle(4);
        data_stall = 1'b1;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h200 + 32'(4*i), 4'h0, 32'h0);
        req = 1'b1; wr = 1'b0; addr = 32'h210;
        repeat (3) begin
            @(negedge clk);
            chk1("t3_full_addr_ok", addr_ok, 1'b0);
            chk1("t3_stall_data_ok", data_ok, 1'b0);
        end
        sync();
        data_stall = 1'b0;
        @(negedge clk);
        chk1("t3_nobypass_addr_ok", addr_ok, 1'b0);
        chk1("t3_first_data_ok", data_ok, 1'b1);
        chk("t3_first_rdata", rdata, 32'hA000_0000);
        sync();
        @(negedge clk);
        chk1("t3_reopen_addr_ok", addr_ok, 1'b1);
        chk("t3_second_rdata", rdata, 32'hA000_0001);
        sync();
        issue(1'b0, 32'h214, 4'h0, 32'h0);
        idle(8);

        // 4: addr_stall blocks acceptance with req held
        addr_stall = 1'b1;
        req = 1'b1; wr = 1'b0; addr = 32'h100;
        repeat (5) begin
            @(negedge clk);
            chk1("t4_stall_addr_ok", addr_ok, 1'b0);
            chk1("t4_stall_data_ok", data_ok, 1'b0);
        end
        sync();
        addr_stall = 1'b0;
        @(negedge clk);
        chk1("t4_release_addr_ok", addr_ok, 1'b1);
        sync();
        req = 1'b0;
        idle(4);

        // 5: reset with three reads pending
        data_stall = 1'b1;
        issue(1'b0, 32'h200, 4'h0, 32'h0);
        issue(1'b0, 32'h204, 4'h0, 32'h0);
        issue(1'b0, 32'h208, 4'h0, 32'h0);
        reset = 1'b1;
        data_stall = 1'b0;
        #1;
        chk1("t5_rst_addr_ok", addr_ok, 1'b0);
        chk1("t5_rst_data_ok", data_ok, 1'b0);
        chk("t5_rst_rdata", rdata, 32'h0);
        idle(2);
        reset = 1'b0;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_ok) stale++;
        end
        chk("t5_stale_responses", 32'(stale), 32'h0);
        sync();
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk1("t5_after_data_ok", data_ok, 1'b1);
        chk("t5_after_rdata", rdata, 32'h12AB_5678);
        sync();
        idle(2);

        // 6: upper address bits alias onto the same word
        issue(1'b1, 32'h0000_1008, 4'hF, 32'hCAFE_F00D);
        idle(3);
        issue(1'b0, 32'h0000_0008, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk1("t6_data_ok", data_ok, 1'b1);
        chk("t6_rdata", rdata, 32'hCAFE_F00D);
        sync();
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
